// File: rtl/interrupt_ack_control.sv
// Request-side controller of an 8259-style PIC: resolves pending unmasked
// requests against the in-service level, raises INT, runs the two-pulse INTA
// handshake, drives the vector byte and decodes OCW2 into EOI/rotation.
module interrupt_ack_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] interrupt_request,
   input  logic [7:0] interrupt_mask,
   input  logic [7:0] highest_level_in_service,
   input  logic       inta_n,
   input  logic       ocw2_wr,
   input  logic [7:0] ocw2,
   input  logic [4:0] vector_base,
   input  logic       auto_eoi,
   output logic       int_out,
   output logic [7:0] interrupt,
   output logic [7:0] clear_irr,
   output logic [7:0] end_of_interrupt,
   output logic [2:0] priority_rotate,
   output logic [7:0] data_out,
   output logic       data_out_en
);

   typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

   state_t     state;
   logic       inta_prev;
   logic       aeoi_rotate;
   logic [2:0] level_q;
   logic       spurious_q;

   logic [7:0] eligible;
   logic [2:0] base;
   logic       winner_found;
   logic [2:0] winner_level;
   logic       isr_found;
   logic [2:0] isr_level;
   logic       grant;
   logic       inta_fall;
   logic       inta_rise;

   logic [7:0] ocw_eoi;
   logic       ocw_rot_load;
   logic [2:0] ocw_rot_val;
   logic       ocw_aeoi_set;
   logic       ocw_aeoi_clr;
   logic [7:0] aeoi_eoi;
   logic       aeoi_rot_load;

   // Bits 4:3 of OCW2 only select OCW2 vs OCW3 upstream; not needed here.
   logic       ocw2_unused;
   assign ocw2_unused = ^ocw2[4:3];

   assign eligible  = interrupt_request & ~interrupt_mask;
   assign base      = priority_rotate + 3'd1;
   assign inta_fall = inta_prev & ~inta_n;
   assign inta_rise = ~inta_prev & inta_n;

   // Rotating priority search over requests and in-service bits; the lowest
   // rank (distance from the highest-priority level) wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      winner_found = 1'b0;
      winner_level = 3'd0;
      isr_found    = 1'b0;
      isr_level    = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (eligible[base + 3'(i)]) begin
            winner_found = 1'b1;
            winner_level = base + 3'(i);
         end
         if (highest_level_in_service[base + 3'(i)]) begin
            isr_found = 1'b1;
            isr_level = base + 3'(i);
         end
      end
      grant = winner_found &&
              (!isr_found || ((winner_level - base) < (isr_level - base)));
   end

   // OCW2 command decode: EOI mask, rotation load and AEOI-rotate control.
   always_comb begin
      ocw_eoi      = 8'h00;
      ocw_rot_load = 1'b0;
      ocw_rot_val  = ocw2[2:0];
      ocw_aeoi_set = 1'b0;
      ocw_aeoi_clr = 1'b0;
      if (ocw2_wr) begin
         case (ocw2[7:5])
            3'b001: ocw_eoi = highest_level_in_service;
            3'b011: ocw_eoi = 8'h01 << ocw2[2:0];
            3'b101: begin
               ocw_eoi      = highest_level_in_service;
               ocw_rot_load = isr_found;
               ocw_rot_val  = isr_level;
            end
            3'b111: begin
               ocw_eoi      = 8'h01 << ocw2[2:0];
               ocw_rot_load = 1'b1;
            end
            3'b110: ocw_rot_load = 1'b1;
            3'b100: ocw_aeoi_set = 1'b1;
            3'b000: ocw_aeoi_clr = 1'b1;
            default: ;
         endcase
      end
   end

   // Automatic EOI fires on the closing INTA rising edge of a real acknowledge.
   always_comb begin
      aeoi_eoi      = 8'h00;
      aeoi_rot_load = 1'b0;
      if (state == ACK2 && inta_rise && auto_eoi && !spurious_q) begin
         aeoi_eoi      = 8'h01 << level_q;
         aeoi_rot_load = aeoi_rotate;
      end
   end

   // Acknowledge FSM plus all registered outputs and rotation state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         inta_prev        <= 1'b1;
         aeoi_rotate      <= 1'b0;
         level_q          <= 3'd0;
         spurious_q       <= 1'b0;
         int_out          <= 1'b0;
         interrupt        <= 8'h00;
         clear_irr        <= 8'h00;
         end_of_interrupt <= 8'h00;
         priority_rotate  <= 3'b111;
         data_out         <= 8'h00;
         data_out_en      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the statement order.
         inta_prev        <= inta_n;
         interrupt        <= 8'h00;
         clear_irr        <= 8'h00;
         end_of_interrupt <= ocw_eoi | aeoi_eoi;

         if (ocw_rot_load) begin
            priority_rotate <= ocw_rot_val;
         end else if (aeoi_rot_load) begin
            priority_rotate <= level_q;
         end

         if (ocw_aeoi_set) begin
            aeoi_rotate <= 1'b1;
         end else if (ocw_aeoi_clr) begin
            aeoi_rotate <= 1'b0;
         end

         case (state)
            IDLE: begin
               int_out <= grant;
               if (inta_fall && int_out) begin
                  int_out <= 1'b0;
                  state   <= ACK1;
                  if (grant) begin
                     level_q    <= winner_level;
                     spurious_q <= 1'b0;
                     interrupt  <= 8'h01 << winner_level;
                     clear_irr  <= 8'h01 << winner_level;
                  end else begin
                     level_q    <= 3'd7;
                     spurious_q <= 1'b1;
                  end
               end
            end
            ACK1: begin
               if (inta_fall) begin
                  data_out    <= {vector_base, level_q};
                  data_out_en <= 1'b1;
                  state       <= ACK2;
               end
            end
            ACK2: begin
               if (inta_rise) begin
                  data_out    <= 8'h00;
                  data_out_en <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
